mult_div_unit: RTL

Iterative multiply/divide unit for the execute stage of the pipeline. It takes the two register operands read from the register file, runs a signed or unsigned 32-bit multiply or divide over multiple cycles, and returns a 64-bit result on `busmult` with a one-cycle `multWe` strobe. The register file commits that strobe into High/Low on the following negative clock edge. `busy` lets the hazard unit stall MFHI/MFLO and any further mult/div until the result has landed.

---
 rtl/mult_div_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit for the execute stage. Runs a signed or
//   unsigned WIDTH-bit multiply (shift-add) or divide (restoring
//   shift-subtract), one iteration per clock, and returns a 2*WIDTH-bit
//   result with a one-cycle write strobe for the High/Low registers.
//
//   Configuration macro: MDU_DIV_EN
//     defined   : MULT, MULTU, DIV, DIVU supported.
//     undefined : divider datapath compiled out; divide requests are ignored.
//
// Ports
//   clk      in   pipeline clock, rising-edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   op       in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   busA     in   W   multiplicand / dividend
//   busB     in   W   multiplier / divisor
//   flush    in   synchronous abort of the operation in flight
//   busy     out  high from the accepting edge until the unit is idle again
//   multWe   out  one-cycle result-valid / High-Low write strobe
//   busmult  out  2W  {High, Low}: product, or {remainder, quotient}
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   busA,
  input  logic [WIDTH-1:0]   busB,
  input  logic               flush,
  output logic               busy,
  output logic               multWe,
  output logic [2*WIDTH-1:0] busmult
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;     // mult: {partial hi, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   mcand;   // multiplicand or divisor magnitude
  logic               sign_a, sign_b;
  logic               is_div;

  // Request decode
  logic               op_signed, req_div, op_ok, accept, last;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign op_signed = ~op[0];
  assign req_div   = op[1];
  assign mag_a     = (op_signed && busA[WIDTH-1]) ? -busA : busA;
  assign mag_b     = (op_signed && busB[WIDTH-1]) ? -busB : busB;
`ifdef MDU_DIV_EN
  assign op_ok     = 1'b1;
`else
  assign op_ok     = ~req_div;
`endif
  assign accept    = (state == S_IDLE) && start && !flush && op_ok;
  assign last      = (cnt == CW'(WIDTH - 1));

  // Multiply step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right. The carry
  // out of the add becomes the new top bit.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_res;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign mul_res  = (sign_a ^ sign_b) ? -acc : acc;

`ifdef MDU_DIV_EN
  // Restoring divide step: shift the next dividend bit into the remainder
  // (guard bit on top), trial-subtract, keep the difference if non-negative.
  // A zero divisor always "succeeds", which yields quotient all-ones and the
  // dividend magnitude as remainder without any special datapath.
  logic               b_zero;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] div_next, div_res;
  logic [WIDTH-1:0]   quo, rem;

  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mcand};
  assign div_next  = div_trial[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign rem       = acc[2*WIDTH-1:WIDTH];
  assign quo       = acc[WIDTH-1:0];
  // Divide-by-zero bypasses the quotient negation so it stays all ones.
  assign div_res   = {(sign_a ? -rem : rem),
                      ((sign_a ^ sign_b) && !b_zero) ? -quo : quo};
`endif

  logic [2*WIDTH-1:0] step_next, fix_res;

`ifdef MDU_DIV_EN
  assign step_next = is_div ? div_next : mul_next;
  assign fix_res   = is_div ? div_res  : mul_res;
`else
  assign step_next = mul_next;
  assign fix_res   = mul_res;
`endif

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (accept) next_state = S_CALC;
      S_CALC: begin
        if (flush)     next_state = S_IDLE;
        else if (last) next_state = S_FIX;
      end
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath and registered outputs. busy stays up through the strobe cycle
  // (the unit is already back in IDLE then) so the hazard unit cannot issue
  // MFHI/MFLO before High/Low has been written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      multWe  <= 1'b0;
      busmult <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      is_div  <= 1'b0;
`ifdef MDU_DIV_EN
      b_zero  <= 1'b0;
`endif
    end else begin
      busy   <= accept || ((state != S_IDLE) && !flush);
      multWe <= (state == S_FIX) && !flush;

      if (accept) begin
        sign_a <= op_signed & busA[WIDTH-1];
        sign_b <= op_signed & busB[WIDTH-1];
        is_div <= req_div;
        cnt    <= '0;
        mcand  <= req_div ? mag_b : mag_a;
        acc    <= {{WIDTH{1'b0}}, (req_div ? mag_a : mag_b)};
`ifdef MDU_DIV_EN
        b_zero <= (busB == '0);
`endif
      end else if (state == S_CALC) begin
        acc <= step_next;
        cnt <= last ? '0 : cnt + CW'(1);
      end

      if ((state == S_FIX) && !flush) busmult <= fix_res;
    end
  end

endmodule
